// File: rtl/adc_align_pkg.sv
// Shared types and helpers for the ADC word aligner: sample geometry,
// alignment FSM states and the per-lane bit-rotate function.
package adc_align_pkg;

    localparam int unsigned SAMPLE_WIDTH = 14;
    localparam int unsigned LANES        = 4;
    localparam int unsigned BUS_WIDTH    = SAMPLE_WIDTH * LANES;
    localparam int unsigned OFFSET_WIDTH = 4;

    typedef enum logic [2:0] {
        StIdle,
        StSearch,
        StVerify,
        StLocked,
        StFail
    } align_state_e;

    // Rotate left: bit i moves to (i + amt) mod SAMPLE_WIDTH. amt must be < SAMPLE_WIDTH.
    function automatic logic [SAMPLE_WIDTH-1:0] rotl_sample(
        input logic [SAMPLE_WIDTH-1:0] x,
        input logic [OFFSET_WIDTH-1:0] amt
    );
        logic [2*SAMPLE_WIDTH-1:0] dbl;
        dbl = {x, x} << amt;
        return dbl[2*SAMPLE_WIDTH-1 -: SAMPLE_WIDTH];
    endfunction

endpackage

// File: rtl/adc_word_aligner_if.sv
// Parallel sample bus between the deserializer, the aligner and the DSP chain.
// master = upstream/downstream environment, slave = the aligner.
interface adc_word_aligner_if;
    import adc_align_pkg::*;

    logic [BUS_WIDTH-1:0] din_a;
    logic [BUS_WIDTH-1:0] din_b;
    logic [BUS_WIDTH-1:0] dout_a;
    logic [BUS_WIDTH-1:0] dout_b;
    logic                 dout_valid;

    modport master (
        output din_a,
        output din_b,
        input  dout_a,
        input  dout_b,
        input  dout_valid
    );

    modport slave (
        input  din_a,
        input  din_b,
        output dout_a,
        output dout_b,
        output dout_valid
    );

endinterface

// File: rtl/adc_lane_rotator.sv
// One 14-bit lane: rotate left by the shared offset and register the result.
module adc_lane_rotator
    import adc_align_pkg::*;
(
    input  logic                    lvds_clk,
    input  logic                    rst,
    input  logic [SAMPLE_WIDTH-1:0] din,
    input  logic [OFFSET_WIDTH-1:0] offset,
    output logic [SAMPLE_WIDTH-1:0] dout
);

    logic [SAMPLE_WIDTH-1:0] rot_q;

    // Stage-2 register holding the rotated lane.
    always_ff @(posedge lvds_clk) begin
        if (rst) begin
            rot_q <= '0;
        end else begin
            rot_q <= rotl_sample(din, offset);
        end
    end

    assign dout = rot_q;

endmodule

// File: rtl/adc_word_aligner.sv
// ADC word aligner: finds the bit rotation that restores 14-bit word alignment on
// both ADCs using the training pattern, then passes aligned samples with a valid flag.
// Optional build macro ADC_ALIGN_STATS_EN adds a saturating mismatch_cnt output.
module adc_word_aligner
    import adc_align_pkg::*;
#(
    parameter logic [SAMPLE_WIDTH-1:0] TRAIN_PATTERN = 14'h2A5C,
    parameter int unsigned             DWELL         = 16,
    parameter int unsigned             MATCH_TARGET  = 64
) (
    input  logic                    lvds_clk,
    input  logic                    rst,
    input  logic                    train_start,
    adc_word_aligner_if.slave       bus,
    output logic                    locked,
    output logic                    align_fail,
    output logic [OFFSET_WIDTH-1:0] offset
`ifdef ADC_ALIGN_STATS_EN
    ,
    output logic [15:0]             mismatch_cnt
`endif
);

    localparam int unsigned DWELL_W = $clog2(DWELL);
    localparam int unsigned MATCH_W = $clog2(MATCH_TARGET);
    localparam int unsigned SETTLE_W = 2;
    localparam logic [SETTLE_W-1:0] SETTLE_LOAD = 2'd2;
    localparam logic [OFFSET_WIDTH-1:0] LAST_OFFSET = OFFSET_WIDTH'(SAMPLE_WIDTH - 1);

    logic [BUS_WIDTH-1:0] s1_a_q, s1_b_q;
    logic [BUS_WIDTH-1:0] s2_a, s2_b;

    align_state_e            state_q, state_d;
    logic [OFFSET_WIDTH-1:0] offset_q, offset_d;
    logic [SETTLE_W-1:0]     settle_q, settle_d;
    logic [DWELL_W-1:0]      dwell_q, dwell_d;
    logic [MATCH_W-1:0]      match_cnt_q, match_cnt_d;
    logic                    match;
    logic                    eval;

    // Stage 1: capture raw deserializer words.
    always_ff @(posedge lvds_clk) begin
        if (rst) begin
            s1_a_q <= '0;
            s1_b_q <= '0;
        end else begin
            s1_a_q <= bus.din_a;
            s1_b_q <= bus.din_b;
        end
    end

    // Stage 2: one rotator per lane, all sharing the same offset.
    for (genvar i = 0; i < LANES; i++) begin : g_lane
        adc_lane_rotator u_rot_a (
            .lvds_clk (lvds_clk),
            .rst      (rst),
            .din      (s1_a_q[i*SAMPLE_WIDTH +: SAMPLE_WIDTH]),
            .offset   (offset_q),
            .dout     (s2_a[i*SAMPLE_WIDTH +: SAMPLE_WIDTH])
        );
        adc_lane_rotator u_rot_b (
            .lvds_clk (lvds_clk),
            .rst      (rst),
            .din      (s1_b_q[i*SAMPLE_WIDTH +: SAMPLE_WIDTH]),
            .offset   (offset_q),
            .dout     (s2_b[i*SAMPLE_WIDTH +: SAMPLE_WIDTH])
        );
    end

    // All eight aligned lanes must show the training word.
    always_comb begin
        match = 1'b1;
        for (int i = 0; i < LANES; i++) begin
            if (s2_a[i*SAMPLE_WIDTH +: SAMPLE_WIDTH] != TRAIN_PATTERN) match = 1'b0;
            if (s2_b[i*SAMPLE_WIDTH +: SAMPLE_WIDTH] != TRAIN_PATTERN) match = 1'b0;
        end
    end

    // Pipeline still holds data rotated by the previous offset while settle is nonzero.
    assign eval = (settle_q == '0);

    // FSM state, offset and counter registers.
    always_ff @(posedge lvds_clk) begin
        if (rst) begin
            state_q     <= StIdle;
            offset_q    <= '0;
            settle_q    <= '0;
            dwell_q     <= '0;
            match_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            offset_q    <= offset_d;
            settle_q    <= settle_d;
            dwell_q     <= dwell_d;
            match_cnt_q <= match_cnt_d;
        end
    end

    // Next-state logic: search offsets, verify a candidate, lock or give up.
    always_comb begin
        state_d     = state_q;
        offset_d    = offset_q;
        settle_d    = settle_q;
        dwell_d     = dwell_q;
        match_cnt_d = match_cnt_q;
        if (settle_q != '0) settle_d = settle_q - 1'b1;

        unique case (state_q)
            StIdle: begin
            end
            StSearch: begin
                if (eval) begin
                    if (match) begin
                        state_d     = StVerify;
                        match_cnt_d = MATCH_W'(1);
                        dwell_d     = '0;
                    end else if (dwell_q == DWELL_W'(DWELL - 1)) begin
                        dwell_d = '0;
                        if (offset_q == LAST_OFFSET) begin
                            state_d = StFail;
                        end else begin
                            offset_d = offset_q + 1'b1;
                            settle_d = SETTLE_LOAD;
                        end
                    end else begin
                        dwell_d = dwell_q + 1'b1;
                    end
                end
            end
            StVerify: begin
                if (match) begin
                    if (match_cnt_q == MATCH_W'(MATCH_TARGET - 1)) begin
                        state_d     = StLocked;
                        match_cnt_d = '0;
                    end else begin
                        match_cnt_d = match_cnt_q + 1'b1;
                    end
                end else begin
                    match_cnt_d = '0;
                    if (offset_q == LAST_OFFSET) begin
                        state_d = StFail;
                    end else begin
                        state_d  = StSearch;
                        offset_d = offset_q + 1'b1;
                        settle_d = SETTLE_LOAD;
                    end
                end
            end
            StLocked, StFail: begin
            end
            default: state_d = StIdle;
        endcase

        // Restart overrides everything, including a lock decision in the same cycle.
        if (train_start) begin
            state_d     = StSearch;
            offset_d    = '0;
            settle_d    = SETTLE_LOAD;
            dwell_d     = '0;
            match_cnt_d = '0;
        end
    end

    assign bus.dout_a     = s2_a;
    assign bus.dout_b     = s2_b;
    assign bus.dout_valid = (state_q == StLocked);
    assign locked         = (state_q == StLocked);
    assign align_fail     = (state_q == StFail);
    assign offset         = offset_q;

`ifdef ADC_ALIGN_STATS_EN
    logic [15:0] mismatch_cnt_q;

    // Count post-settle non-matching cycles while hunting; saturates.
    always_ff @(posedge lvds_clk) begin
        if (rst || train_start) begin
            mismatch_cnt_q <= '0;
        end else if (eval && !match && (state_q == StSearch || state_q == StVerify)
                     && mismatch_cnt_q != 16'hFFFF) begin
            mismatch_cnt_q <= mismatch_cnt_q + 16'd1;
        end
    end

    assign mismatch_cnt = mismatch_cnt_q;
`endif

endmodule

// File: tb/tb_adc_word_aligner.sv
// Directed bench for adc_word_aligner: lock timing, offset search, failure,
// restart/reset priority. Stats checks compile in with ADC_ALIGN_STATS_EN.
module tb_adc_word_aligner;
    import adc_align_pkg::*;

    localparam logic [13:0] PAT      = 14'h2A5C;
    localparam logic [13:0] PAT_ROT5 = 14'h3952;  // PAT rotated right by 5

    logic        lvds_clk = 1'b0;
    logic        rst = 1'b1;
    logic        train_start = 1'b0;
    logic        locked;
    logic        align_fail;
    logic [3:0]  offset;
`ifdef ADC_ALIGN_STATS_EN
    logic [15:0] mismatch_cnt;
`endif

    int vectors = 0;
    int miscompares = 0;

    logic [55:0] aligned_word;
    logic [55:0] rot5_word;
    logic [55:0] corrupt_word;
    logic [63:0] rnd;

    adc_word_aligner_if bus ();

    adc_word_aligner dut (
        .lvds_clk     (lvds_clk),
        .rst          (rst),
        .train_start  (train_start),
        .bus          (bus),
        .locked       (locked),
        .align_fail   (align_fail),
        .offset       (offset)
`ifdef ADC_ALIGN_STATS_EN
        ,
        .mismatch_cnt (mismatch_cnt)
`endif
    );

    always #5 lvds_clk = ~lvds_clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance n rising edges, leaving time 1 unit past the last one.
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge lvds_clk);
            #1;
        end
    endtask

    task automatic pulse_train();
        train_start = 1'b1;
        tick(1);
        train_start = 1'b0;
    endtask

    task automatic drive(input logic [55:0] a, input logic [55:0] b);
        bus.din_a = a;
        bus.din_b = b;
    endtask

    initial begin
        aligned_word = {4{PAT}};
        rot5_word    = {4{PAT_ROT5}};
        corrupt_word = {PAT, PAT ^ 14'h0001, PAT, PAT};
        drive('0, '0);

        // Reset values
        tick(3);
        check_eq("rst_locked", {63'd0, locked}, 64'd0);
        check_eq("rst_valid", {63'd0, bus.dout_valid}, 64'd0);
        check_eq("rst_fail", {63'd0, align_fail}, 64'd0);
        check_eq("rst_offset", {60'd0, offset}, 64'd0);
        check_eq("rst_dout_a", {8'd0, bus.dout_a}, 64'd0);
        check_eq("rst_dout_b", {8'd0, bus.dout_b}, 64'd0);
`ifdef ADC_ALIGN_STATS_EN
        check_eq("rst_mm", {48'd0, mismatch_cnt}, 64'd0);
`endif
        rst = 1'b0;

        // Aligned pattern: lock exactly 66 edges after the SEARCH entry edge
        drive(aligned_word, aligned_word);
        tick(3);
        check_eq("idle_locked", {63'd0, locked}, 64'd0);
        pulse_train();
        check_eq("a0_offset", {60'd0, offset}, 64'd0);
        tick(65);
        check_eq("a0_pre_lock", {63'd0, locked}, 64'd0);
        tick(1);
        check_eq("a0_lock", {63'd0, locked}, 64'd1);
        check_eq("a0_valid", {63'd0, bus.dout_valid}, 64'd1);
        check_eq("a0_dout_a", {8'd0, bus.dout_a}, {8'd0, aligned_word});
        tick(10);
        check_eq("a0_valid_hold", {63'd0, bus.dout_valid}, 64'd1);
`ifdef ADC_ALIGN_STATS_EN
        check_eq("a0_mm", {48'd0, mismatch_cnt}, 64'd0);
`endif

        // Restart while LOCKED clears status on the next edge
        pulse_train();
        check_eq("rs_locked", {63'd0, locked}, 64'd0);
        check_eq("rs_valid", {63'd0, bus.dout_valid}, 64'd0);
        check_eq("rs_offset", {60'd0, offset}, 64'd0);

        // Pattern rotated right by 5: offsets 0..4 dwell 18 cycles each
        drive(rot5_word, rot5_word);
        pulse_train();
        tick(89);
        check_eq("r5_offset4", {60'd0, offset}, 64'd4);
        tick(1);
        check_eq("r5_offset5", {60'd0, offset}, 64'd5);
        tick(65);
        check_eq("r5_pre_lock", {63'd0, locked}, 64'd0);
        tick(1);
        check_eq("r5_lock", {63'd0, locked}, 64'd1);
        check_eq("r5_offset", {60'd0, offset}, 64'd5);
        check_eq("r5_a_lane0", {50'd0, bus.dout_a[13:0]}, {50'd0, PAT});
        check_eq("r5_b_lane3", {50'd0, bus.dout_b[55:42]}, {50'd0, PAT});
`ifdef ADC_ALIGN_STATS_EN
        check_eq("r5_mm", {48'd0, mismatch_cnt}, 64'd80);
`endif

        // One corrupted lane during verify cycle 30
        drive(aligned_word, aligned_word);
        pulse_train();
        tick(30);
        drive(corrupt_word, aligned_word);
        tick(1);
        drive(aligned_word, aligned_word);
        tick(1);
        check_eq("cor_offset_pre", {60'd0, offset}, 64'd0);
        tick(1);
        check_eq("cor_offset", {60'd0, offset}, 64'd1);
        check_eq("cor_locked", {63'd0, locked}, 64'd0);
`ifdef ADC_ALIGN_STATS_EN
        check_eq("cor_mm", {48'd0, mismatch_cnt}, 64'd1);
`endif

        // Restart coinciding with the lock decision wins
        pulse_train();
        tick(65);
        train_start = 1'b1;
        tick(1);
        train_start = 1'b0;
        check_eq("tie_locked", {63'd0, locked}, 64'd0);
        check_eq("tie_offset", {60'd0, offset}, 64'd0);
        tick(65);
        check_eq("tie_pre_relock", {63'd0, locked}, 64'd0);
        tick(1);
        check_eq("tie_relock", {63'd0, locked}, 64'd1);

        // Random data: fail after 14 x 18 cycles
        rnd = {$urandom(), $urandom()};
        drive(rnd[55:0], {rnd[27:0], rnd[63:36]});
        pulse_train();
        for (int n = 0; n < 251; n++) begin
            rnd = {$urandom(), $urandom()};
            drive(rnd[55:0], {rnd[27:0], rnd[63:36]});
            tick(1);
        end
        check_eq("rnd_pre_fail", {63'd0, align_fail}, 64'd0);
        check_eq("rnd_offset13", {60'd0, offset}, 64'd13);
        tick(1);
        check_eq("rnd_fail", {63'd0, align_fail}, 64'd1);
        check_eq("rnd_locked", {63'd0, locked}, 64'd0);
        check_eq("rnd_offset", {60'd0, offset}, 64'd13);
`ifdef ADC_ALIGN_STATS_EN
        check_eq("rnd_mm", {48'd0, mismatch_cnt}, 64'd224);
`endif
        tick(5);
        check_eq("rnd_fail_hold", {63'd0, align_fail}, 64'd1);
        check_eq("rnd_offset_hold", {60'd0, offset}, 64'd13);

        // Restart from FAIL, then reset mid-VERIFY
        drive(aligned_word, aligned_word);
        pulse_train();
        check_eq("fr_fail_clr", {63'd0, align_fail}, 64'd0);
        tick(20);
        rst = 1'b1;
        tick(1);
        check_eq("mr_locked", {63'd0, locked}, 64'd0);
        check_eq("mr_valid", {63'd0, bus.dout_valid}, 64'd0);
        check_eq("mr_fail", {63'd0, align_fail}, 64'd0);
        check_eq("mr_offset", {60'd0, offset}, 64'd0);
        check_eq("mr_dout_a", {8'd0, bus.dout_a}, 64'd0);
`ifdef ADC_ALIGN_STATS_EN
        check_eq("mr_mm", {48'd0, mismatch_cnt}, 64'd0);
`endif
        rst = 1'b0;
        tick(100);
        check_eq("mr_no_lock", {63'd0, locked}, 64'd0);
        check_eq("mr_dout_live", {8'd0, bus.dout_a}, {8'd0, aligned_word});

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/adc_word_aligner.md
Name: adc_word_aligner

Overview:
- Sits directly downstream of the LVDS deserializer stage on lvds_clk.
- Consumes the two ADCs' 4-sample-per-cycle parallel words (4 x 14 bit per ADC).
- Finds the bit rotation that restores word alignment, using the ADC training pattern; one rotation is shared by both ADCs because they use the same PLL.
- Once locked, emits rotated, aligned samples with a valid flag to the DSP chain.

Parameters:
SAMPLE_WIDTH, 14, bits per ADC sample
LANES, 4, samples per lvds_clk cycle per ADC
TRAIN_PATTERN, 14'h2A5C, ADC test-pattern word expected on every lane when aligned
DWELL, 16, cycles spent seeking a match at one offset before advancing
MATCH_TARGET, 64, consecutive matching cycles required to declare lock

Ports:
lvds_clk  in  1  parallel-domain clock from the deserializer PLL
rst  in  1  synchronous, active-high reset
train_start  in  1  one-cycle pulse: restart alignment search from offset 0
din_a  in  56  ADC A samples; lane0 = [13:0] (oldest) ... lane3 = [55:42]
din_b  in  56  ADC B samples; same packing
dout_a  out  56  aligned ADC A samples; same packing
dout_b  out  56  aligned ADC B samples
dout_valid  out  1  high only in LOCKED
locked  out  1  high in LOCKED
align_fail  out  1  high in FAIL
offset  out  4  current rotation, 0..13

Behaviour:
- Clock/reset: one clock, lvds_clk. Reset is synchronous and active-high on rst, and has priority over everything.
- Reset values: all outputs 0; state IDLE; offset 0; counters 0.
- Datapath, 2-stage pipeline:
  - Stage 1 registers din_a and din_b.
  - Stage 2 rotates each 14-bit lane left by offset (bit i moves to (i+offset) mod 14) and registers the result.
  - dout_a/dout_b equal stage-2 registers; latency is 2 cycles. dout always follows data; consumers qualify with dout_valid.
- match = all 8 stage-2 lanes equal TRAIN_PATTERN.
- settle: 2-cycle counter loaded on every offset change and on entry to SEARCH. While settle is nonzero, match is ignored.
- FSM:
  - IDLE: wait for train_start -> SEARCH with offset=0.
  - SEARCH: dwell counter counts valid (post-settle) cycles.
    - match -> VERIFY with match counter = 1.
    - dwell reaches DWELL with no match -> offset+1 and stay in SEARCH; if offset was 13 -> FAIL.
  - VERIFY: each match increments the match counter.
    - Counter reaches MATCH_TARGET -> LOCKED.
    - Any mismatch -> advance offset (13 -> FAIL) and go to SEARCH.
  - LOCKED: dout_valid=1 and locked=1. The pattern is not checked, since live data follows.
  - FAIL: align_fail=1; offset holds at 13.
- train_start in any state other than reset: next cycle -> SEARCH, offset=0, counters cleared, locked/dout_valid/align_fail cleared that same next cycle.
- train_start coinciding with the lock decision: train_start wins.
- Counters: widths sized with clog2 of their limit; none wrap (state changes first).

Optional Feature:
Macro ADC_ALIGN_STATS_EN.
- Defined: adds output mismatch_cnt (16 bit, saturating at 16'hFFFF).
  - Increments on every post-settle cycle in SEARCH or VERIFY where match=0.
  - Cleared by rst and train_start; holds in LOCKED, FAIL and IDLE.
- Undefined: the port and counter are absent; all other behaviour is identical.

Decomposition:
- Package adc_align_pkg holds:
  - FSM state enum (IDLE, SEARCH, VERIFY, LOCKED, FAIL);
  - SAMPLE_WIDTH/LANES localparams;
  - the 14-bit rotate function.
- One sub-module: adc_lane_rotator (single 14-bit lane rotate plus register), instantiated 8 times.

Test Plan:
- Feed TRAIN_PATTERN pre-rotated right by 5 on all lanes, then pulse train_start -> offset steps 0..5 and locked rises once 64 consecutive matches at offset 5 are counted; dout_a lane0 = 14'h2A5C.
- Aligned pattern (offset 0) -> locked after 2 settle + 64 cycles from the SEARCH entry cycle; dout_valid=1 and stays high.
- Random data with no pattern -> align_fail after 14 offsets x (2+16) cycles; offset=13, locked=0.
- Single corrupted lane at verify cycle 30 -> return to SEARCH with offset+1; mismatch_cnt=1 when stats are enabled.
- Pulse train_start while LOCKED -> next cycle locked=0, offset=0, state SEARCH.
- Assert rst mid-VERIFY -> all outputs 0 and IDLE on the next edge; no lock without a new train_start.
